pktgen_arbiter: RTL

Round-robin, packet-granular arbiter that shares one 32-bit AXI-network packet stream (the CRC calculator / Ethernet model input path) among NIN packet generators in the source clock domain. A grant is held for a whole packet and released on LAST or ABORT. A watchdog aborts packets whose source stalls mid-packet. The output is fully registered so the downstream CRC and model inputs see clean, stable beats.

---
 rtl/pktgen_arbiter.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pktgen_arbiter.sv
// pktgen_arbiter
//
// Packet-granular round-robin arbiter. It merges NIN packet sources onto one
// fully registered output stream. A grant is held for a whole packet and is
// released on LAST or ABORT. A watchdog aborts any packet whose source stalls
// mid-packet. Once a source has been timed out, its leftover beats are
// flushed: they are accepted and dropped until its LAST beat or an ABORT.
//
// Ports
//   S_AXI_ACLK  clock
//   i_reset     synchronous active-high reset
//   S_VALID     per-source beat valid                      [NIN]
//   S_READY     per-source accept (combinational)          [NIN]
//   S_DATA      per-source data, source k at [k*DW +: DW]  [NIN*DW]
//   S_BYTES     per-source byte count of the final beat    [NIN*BW]
//   S_LAST      per-source last beat                       [NIN]
//   S_ABORT     per-source abort, valid without S_VALID    [NIN]
//   M_VALID/M_READY/M_DATA/M_BYTES/M_LAST  registered output beat
//   M_ABORT     registered abort marker, never with M_VALID
//   o_grant     one-hot current grant, 0 when idle         [NIN]
//   o_busy      high in BUSY or ABORTING
//   o_timeouts  saturating watchdog abort count            [16]
module pktgen_arbiter #(
  parameter int NIN       = 4,
  parameter int DW        = 32,
  parameter int BW        = 2,
  parameter int LGTIMEOUT = 10
) (
  input  logic              S_AXI_ACLK,
  input  logic              i_reset,
  input  logic [NIN-1:0]    S_VALID,
  output logic [NIN-1:0]    S_READY,
  input  logic [NIN*DW-1:0] S_DATA,
  input  logic [NIN*BW-1:0] S_BYTES,
  input  logic [NIN-1:0]    S_LAST,
  input  logic [NIN-1:0]    S_ABORT,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [DW-1:0]     M_DATA,
  output logic [BW-1:0]     M_BYTES,
  output logic              M_LAST,
  output logic              M_ABORT,
  output logic [NIN-1:0]    o_grant,
  output logic              o_busy,
  output logic [15:0]       o_timeouts
);

  localparam int IW = (NIN > 1) ? $clog2(NIN) : 1;
  localparam logic [LGTIMEOUT:0] WD_LIMIT = {1'b1, {LGTIMEOUT{1'b0}}};
  localparam logic [LGTIMEOUT:0] WD_LAST  = {1'b0, {LGTIMEOUT{1'b1}}};
  localparam logic [LGTIMEOUT:0] WD_ONE   = {{LGTIMEOUT{1'b0}}, 1'b1};
  localparam logic [IW-1:0]      IDX_RST  = IW'(NIN - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_ABORTING = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NIN-1:0]     grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;      // current / last granted source
  logic               mvalid_q, mvalid_d;
  logic               mabort_q, mabort_d;
  logic [DW-1:0]      mdata_q, mdata_d;
  logic [BW-1:0]      mbytes_q, mbytes_d;
  logic               mlast_q, mlast_d;
  logic               busy_q, busy_d;
  logic [15:0]        tmo_q, tmo_d;
  logic [NIN-1:0]     flush_q, flush_d;
  logic [LGTIMEOUT:0] wd_q, wd_d;

  logic               slot_free;
  logic               g_valid, g_abort, g_last;
  logic [DW-1:0]      g_data;
  logic [BW-1:0]      g_bytes;
  logic [NIN-1:0]     req;
  logic               wd_stall, wd_hit;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // First requester strictly after 'last', wrapping. Scanning from the
  // farthest offset down lets the nearest requester overwrite the pick.
  function automatic logic [IW-1:0] rr_pick(input logic [NIN-1:0] r,
                                            input logic [IW-1:0]  last);
    logic [IW-1:0] pick;
    int            idx;
    pick = last;
    for (int i = NIN; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= NIN) idx = idx - NIN;
      if (r[idx[IW-1:0]]) pick = idx[IW-1:0];
    end
    return pick;
  endfunction

  // The output slot can take a new beat or abort marker this cycle.
  assign slot_free = !mvalid_q || M_READY;

  always_comb begin
    g_valid = 1'b0;
    g_abort = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    g_bytes = '0;
    for (int k = 0; k < NIN; k++) begin
      if (int'(gidx_q) == k) begin
        g_valid = S_VALID[k];
        g_abort = S_ABORT[k];
        g_last  = S_LAST[k];
        g_data  = S_DATA[k*DW +: DW];
        g_bytes = S_BYTES[k*BW +: BW];
      end
    end
  end

  // Flushing sources are always drained; the granted source only when the
  // output slot is free.
  always_comb begin
    S_READY = flush_q;
    if (state_q == ST_BUSY && slot_free) S_READY = S_READY | grant_q;
  end

  assign req      = S_VALID & ~S_ABORT & ~flush_q;
  assign wd_stall = !g_valid && !g_abort;
  // The limit is reached either already (held while the slot was busy) or
  // by the stall cycle being counted right now.
  assign wd_hit   = (wd_q == WD_LIMIT) || (wd_stall && wd_q == WD_LAST);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    mvalid_d = mvalid_q;
    mabort_d = mabort_q;
    mdata_d  = mdata_q;
    mbytes_d = mbytes_q;
    mlast_d  = mlast_q;
    busy_d   = busy_q;
    tmo_d    = tmo_q;
    wd_d     = wd_q;

    // A flush ends on the source's LAST beat (always accepted while
    // flushing) or on its ABORT.
    flush_d = flush_q & ~((S_VALID & S_LAST) | S_ABORT);

    if (slot_free) mvalid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gidx_d               = rr_pick(req, gidx_q);
          grant_d              = '0;
          grant_d[gidx_d]      = 1'b1;
          state_d              = ST_BUSY;
          busy_d               = 1'b1;
          wd_d                 = '0;
        end
      end
      ST_BUSY: begin
        if (wd_stall && wd_q != WD_LIMIT) wd_d = wd_q + WD_ONE;
        if (slot_free && (g_abort || wd_hit)) begin
          // Any beat offered alongside the abort is dropped.
          mvalid_d = 1'b0;
          mabort_d = 1'b1;
          grant_d  = '0;
          state_d  = ST_ABORTING;
          if (!g_abort) begin
            tmo_d           = sat_inc16(tmo_q);
            flush_d[gidx_q] = 1'b1;
          end
        end else if (slot_free && g_valid) begin
          mvalid_d = 1'b1;
          mdata_d  = g_data;
          mbytes_d = g_bytes;
          mlast_d  = g_last;
          wd_d     = '0;
          if (g_last) begin
            grant_d = '0;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      ST_ABORTING: begin
        if (M_READY) begin
          mabort_d = 1'b0;
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= IDX_RST;
      mvalid_q <= 1'b0;
      mabort_q <= 1'b0;
      mdata_q  <= '0;
      mbytes_q <= '0;
      mlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      tmo_q    <= '0;
      flush_q  <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      mvalid_q <= mvalid_d;
      mabort_q <= mabort_d;
      mdata_q  <= mdata_d;
      mbytes_q <= mbytes_d;
      mlast_q  <= mlast_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
      flush_q  <= flush_d;
      wd_q     <= wd_d;
    end
  end

  assign M_VALID    = mvalid_q;
  assign M_ABORT    = mabort_q;
  assign M_DATA     = mdata_q;
  assign M_BYTES    = mbytes_q;
  assign M_LAST     = mlast_q;
  assign o_grant    = grant_q;
  assign o_busy     = busy_q;
  assign o_timeouts = tmo_q;

endmodule
